// File: rtl/bip_pkg.sv
// Shared encodings for the BIP control unit: opcodes, mux selects, ALU ops,
// FSM states and the decoded control-strobe bundle.
package bip_pkg;

  localparam int OPC_BITS = 5;

  localparam logic [OPC_BITS-1:0] OPC_HLT  = 5'b00000;
  localparam logic [OPC_BITS-1:0] OPC_STO  = 5'b00001;
  localparam logic [OPC_BITS-1:0] OPC_LD   = 5'b00010;
  localparam logic [OPC_BITS-1:0] OPC_LDI  = 5'b00011;
  localparam logic [OPC_BITS-1:0] OPC_ADD  = 5'b00100;
  localparam logic [OPC_BITS-1:0] OPC_ADDI = 5'b00101;
  localparam logic [OPC_BITS-1:0] OPC_SUB  = 5'b00110;
  localparam logic [OPC_BITS-1:0] OPC_SUBI = 5'b00111;

  localparam logic [1:0] SELA_MEM = 2'b00;
  localparam logic [1:0] SELA_IMM = 2'b01;
  localparam logic [1:0] SELA_ALU = 2'b10;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_FETCH   = 3'd1,
    ST_EXEC    = 3'd2,
    ST_MEMWAIT = 3'd3,
    ST_HALT    = 3'd4
  } state_t;

  typedef struct packed {
    logic       wr_pc;
    logic [1:0] sel_a;
    logic       sel_b;
    logic       wr_acc;
    logic       op;
    logic       rd_ram;
    logic       wr_ram;
    logic       halted;
  } ctrl_t;

  // States that consume a program cycle and therefore advance the run counter.
  function automatic logic is_run_state(state_t s);
    return (s == ST_FETCH) || (s == ST_EXEC) || (s == ST_MEMWAIT);
  endfunction

endpackage

// File: rtl/bip_decoder.sv
// Combinational BIP decode: (state, opcode, start) -> next state and strobes.
// Holds no state; the register lives in bip_control.
module bip_decoder
  import bip_pkg::*;
#(
  parameter int OPC_W = 5
) (
  input  state_t           state,
  input  logic [OPC_W-1:0] opc,
  input  logic             start,
  output state_t           state_nxt,
  output ctrl_t            ctrl
);

  logic is_mem_op;
  assign is_mem_op = (opc == OPC_W'(OPC_LD)) || (opc == OPC_W'(OPC_ADD)) ||
                     (opc == OPC_W'(OPC_SUB));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    state_nxt = start ? ST_FETCH : ST_IDLE;
      ST_FETCH:   state_nxt = ST_EXEC;
      ST_EXEC: begin
        if (opc == OPC_W'(OPC_HLT)) state_nxt = ST_HALT;
        else if (is_mem_op)         state_nxt = ST_MEMWAIT;
        else                        state_nxt = ST_FETCH;
      end
      ST_MEMWAIT: state_nxt = ST_FETCH;
      ST_HALT:    state_nxt = ST_HALT;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl = '0;
    case (state)
      ST_EXEC: begin
        // HLT decodes to all-zero so the pc stays on the HLT address.
        if (opc == OPC_W'(OPC_HLT)) begin
          ctrl = '0;
        end else if (opc == OPC_W'(OPC_STO)) begin
          ctrl.wr_ram = 1'b1;
          ctrl.wr_pc  = 1'b1;
        end else if (opc == OPC_W'(OPC_LDI)) begin
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_IMM;
          ctrl.wr_pc  = 1'b1;
        end else if ((opc == OPC_W'(OPC_ADDI)) || (opc == OPC_W'(OPC_SUBI))) begin
          ctrl.wr_acc = 1'b1;
          ctrl.sel_a  = SELA_ALU;
          ctrl.sel_b  = 1'b1;
          ctrl.op     = (opc == OPC_W'(OPC_SUBI)) ? OP_SUB : OP_ADD;
          ctrl.wr_pc  = 1'b1;
        end else if (is_mem_op) begin
          ctrl.rd_ram = 1'b1;
        end else begin
          ctrl.wr_pc  = 1'b1;
        end
      end
      ST_MEMWAIT: begin
        ctrl.wr_acc = 1'b1;
        ctrl.wr_pc  = 1'b1;
        ctrl.sel_b  = 1'b0;
        if (opc == OPC_W'(OPC_LD)) begin
          ctrl.sel_a = SELA_MEM;
        end else begin
          ctrl.sel_a = SELA_ALU;
          ctrl.op    = (opc == OPC_W'(OPC_SUB)) ? OP_SUB : OP_ADD;
        end
      end
      ST_HALT: ctrl.halted = 1'b1;
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/bip_control.sv
// BIP control unit: state register, instruction register and saturating
// run-cycle counter around the combinational bip_decoder.
module bip_control
  import bip_pkg::*;
#(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 5,
  parameter int OPR_W   = 11,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [INSTR_W-1:0] instr_in,
  output logic               wr_pc,
  output logic [1:0]         sel_a,
  output logic               sel_b,
  output logic               wr_acc,
  output logic               op,
  output logic               rd_ram,
  output logic               wr_ram,
  output logic [OPR_W-1:0]   operand,
  output logic               halted,
  output logic [CNT_W-1:0]   cycles
);

  state_t             state, state_nxt;
  logic [INSTR_W-1:0] ir;
  ctrl_t              ctrl;

  bip_decoder #(.OPC_W(OPC_W)) u_dec (
    .state     (state),
    .opc       (ir[INSTR_W-1 -: OPC_W]),
    .start     (start),
    .state_nxt (state_nxt),
    .ctrl      (ctrl)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Memory data has had a full FETCH cycle to settle when it is captured.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                  ir <= '0;
    else if (state == ST_FETCH) ir <= instr_in;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cycles <= '0;
    else if ((state == ST_IDLE) && start)
      cycles <= '0;
    else if (is_run_state(state) && (cycles != {CNT_W{1'b1}}))
      cycles <= cycles + CNT_W'(1);
  end

  assign wr_pc   = ctrl.wr_pc;
  assign sel_a   = ctrl.sel_a;
  assign sel_b   = ctrl.sel_b;
  assign wr_acc  = ctrl.wr_acc;
  assign op      = ctrl.op;
  assign rd_ram  = ctrl.rd_ram;
  assign wr_ram  = ctrl.wr_ram;
  assign halted  = ctrl.halted;
  assign operand = ir[OPR_W-1:0];

endmodule

// File: tb/tb_bip_control.sv
// Scoreboard bench for bip_control: a program-level model queues the strobe
// events each instruction must produce; a negedge monitor pops and compares.
module tb_bip_control;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [15:0] instr_in;
  logic        wr_pc, sel_b, wr_acc, op, rd_ram, wr_ram, halted;
  logic [1:0]  sel_a;
  logic [10:0] operand;
  logic [15:0] cycles;
  logic        wr_pc_4, sel_b_4, wr_acc_4, op_4, rd_ram_4, wr_ram_4, halted_4;
  logic [1:0]  sel_a_4;
  logic [10:0] operand_4;
  logic [3:0]  cycles_4;

  always #5 clk = ~clk;

  bip_control dut (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .wr_pc(wr_pc), .sel_a(sel_a), .sel_b(sel_b), .wr_acc(wr_acc), .op(op),
    .rd_ram(rd_ram), .wr_ram(wr_ram), .operand(operand), .halted(halted),
    .cycles(cycles)
  );

  bip_control #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .start(start), .instr_in(instr_in),
    .wr_pc(wr_pc_4), .sel_a(sel_a_4), .sel_b(sel_b_4), .wr_acc(wr_acc_4), .op(op_4),
    .rd_ram(rd_ram_4), .wr_ram(wr_ram_4), .operand(operand_4), .halted(halted_4),
    .cycles(cycles_4)
  );

  // Program memory and pc model: data for the current pc is ready within the cycle.
  logic [15:0] mem [0:2047];
  logic [10:0] pc;
  assign instr_in = mem[pc];
  always @(posedge clk or posedge reset)
    if (reset)      pc <= '0;
    else if (wr_pc) pc <= pc + 11'd1;

  typedef struct packed {
    logic [1:0]  sel_a;
    logic        sel_b, wr_acc, op, rd_ram, wr_ram, wr_pc, halted;
    logic [10:0] operand;
    logic [15:0] cycles;
  } ev_t;

  ev_t exp_q[$];
  int  n_cmp = 0, n_bad = 0;
  logic halted_q = 1'b0;

  function automatic ev_t act_ev();
    ev_t e;
    e.sel_a = sel_a; e.sel_b = sel_b; e.wr_acc = wr_acc; e.op = op;
    e.rd_ram = rd_ram; e.wr_ram = wr_ram; e.wr_pc = wr_pc; e.halted = halted;
    e.operand = operand; e.cycles = cycles;
    return e;
  endfunction

  task automatic check(input string nm, input ev_t exp, input ev_t act);
    n_cmp++;
    if (exp !== act) begin
      n_bad++;
      $display("FAIL %s: got %p expected %p", nm, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Walk the program as written: each instruction costs 2 or 3 counted cycles,
  // and emits one event per cycle that carries a strobe (plus the halt entry).
  task automatic model();
    int c = 0;
    for (int i = 0; i < 2048; i++) begin
      logic [4:0]  opc = mem[i][15:11];
      logic [10:0] opd = mem[i][10:0];
      ev_t e = '0;
      e.operand = opd;
      if (opc == 5'd0) begin
        e.halted = 1'b1; e.cycles = 16'(c + 2);
        exp_q.push_back(e);
        break;
      end
      e.cycles = 16'(c + 1);
      if (opc == 5'd2 || opc == 5'd4 || opc == 5'd6) begin
        e.rd_ram = 1'b1;
        exp_q.push_back(e);
        e = '0; e.operand = opd; e.cycles = 16'(c + 2);
        e.wr_acc = 1'b1; e.wr_pc = 1'b1;
        e.sel_a = (opc == 5'd2) ? 2'b00 : 2'b10;
        e.op = (opc == 5'd6);
        exp_q.push_back(e);
        c += 3;
      end else begin
        e.wr_pc = 1'b1;
        if (opc == 5'd1) e.wr_ram = 1'b1;
        if (opc == 5'd3) begin e.wr_acc = 1'b1; e.sel_a = 2'b01; end
        if (opc == 5'd5 || opc == 5'd7) begin
          e.wr_acc = 1'b1; e.sel_a = 2'b10; e.sel_b = 1'b1; e.op = (opc == 5'd7);
        end
        exp_q.push_back(e);
        c += 2;
      end
    end
  endtask

  always @(negedge clk) begin
    ev_t a, e;
    logic hit;
    hit = !reset && ((wr_pc | rd_ram | wr_ram | wr_acc) || (halted && !halted_q));
    halted_q = halted;
    if (hit) begin
      a = act_ev();
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_event: got %p with nothing expected", a);
      end else begin
        e = exp_q.pop_front();
        check("scoreboard", e, a);
        check_int("cycles_cnt4", int'(cycles_4), (e.cycles > 16'd15) ? 15 : int'(e.cycles));
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  // Called just after a rising edge; reset lands mid-cycle.
  task automatic do_reset();
    #2 reset = 1'b1;
    #1;
    check("async_reset", '0, act_ev());
    check_int("async_reset_cnt4", int'(cycles_4), 0);
    exp_q.delete();
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic run_prog();
    bit done = 0;
    logic [15:0] hold;
    model();
    pulse_start();
    for (int k = 0; k < 800 && !done; k++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (halted && exp_q.size() == 0) done = 1;
      else start = !halted && ($urandom_range(0, 7) == 0);
    end
    start = 1'b0;
    check_int("run_completes", int'(done), 1);
    hold = cycles;
    pulse_start();
    pulse_start();
    repeat (4) @(posedge clk);
    #1;
    check_int("halt_cycles_frozen", int'(cycles), int'(hold));
    check_int("halt_held", int'(halted), 1);
    check_int("queue_drained", exp_q.size(), 0);
    do_reset();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0;
    clear_mem();
    #3;
    check("reset_state", '0, act_ev());
    check_int("reset_cnt4", int'(cycles_4), 0);
    @(negedge clk) reset = 1'b0;
    @(posedge clk); #1;

    // Reset while an ADD sits in MEMWAIT.
    clear_mem(); mem[0] = 16'h2003;
    model();
    pulse_start();
    @(posedge clk); @(posedge clk); #1;
    check_int("memwait_reached", int'(wr_acc), 1);
    do_reset();

    clear_mem(); mem[0] = 16'h1805;
    run_prog();

    clear_mem(); mem[0] = 16'h2003;
    run_prog();

    clear_mem(); mem[0] = 16'h3807; mem[1] = 16'h0809; mem[2] = 16'hF8AB;
    mem[3] = 16'h1123; mem[4] = 16'h3001;
    run_prog();

    clear_mem();
    for (int i = 0; i < 10; i++) mem[i] = {5'b00011, 11'(i + 1)};
    run_prog();

    for (int p = 0; p < 6; p++) begin
      int n = $urandom_range(1, 25);
      clear_mem();
      for (int i = 0; i < n; i++) begin
        logic [4:0] opc;
        opc = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(8, 31)) : 5'($urandom_range(1, 7));
        mem[i] = {opc, 11'($urandom_range(0, 2047))};
      end
      run_prog();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bip_control.md
Name: bip_control

Overview:
- Control unit of the BIP processor; sits directly upstream of the program counter and drives its `wr_pc` increment strobe.
- Fetches each instruction from the synchronous program memory that `pc` addresses, then decodes it.
- Sequences accumulator/ALU/data-memory strobes and keeps a run-cycle counter for the host (UART) report.
- Stops at HLT.

Parameters:
- INSTR_W, 16, instruction width
- OPC_W, 5, opcode field width, instr[15:11]
- OPR_W, 11, operand field width, instr[10:0]; equals the pc address width
- CNT_W, 16, run-cycle counter width

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins execution from IDLE
- instr_in  in  INSTR_W  program-memory read data, valid 1 cycle after pc addr changes
- wr_pc  out  1  pc increment strobe
- sel_a  out  2  ACC source: 00 data mem, 01 immediate, 10 ALU result
- sel_b  out  1  ALU operand B: 0 data mem, 1 immediate
- wr_acc  out  1  accumulator write enable
- op  out  1  ALU op: 0 add, 1 sub
- rd_ram  out  1  data-memory read enable
- wr_ram  out  1  data-memory write enable
- operand  out  OPR_W  ir[10:0]; data address / immediate
- halted  out  1  high while in HALT
- cycles  out  CNT_W  executed-cycle count

Behaviour:
- Reset (async, high): state=IDLE, ir=0, cycles=0; every output 0.
- Outputs are a decode of the registered state and ir only. They change only at clock edges and have no combinational path from inputs.
- IDLE: all strobes 0. On start=1 go to FETCH and clear cycles.
- FETCH (1 cycle): waits out program-memory latency; all strobes 0. At the cycle end, ir<=instr_in; go to EXEC.
- EXEC, decode of ir[15:11]:
  - 00000 HLT: no strobes; go to HALT. wr_pc stays 0, so pc holds on the HLT address.
  - 00001 STO: wr_ram=1, wr_pc=1; go to FETCH.
  - 00011 LDI: wr_acc=1, sel_a=01, wr_pc=1; go to FETCH.
  - 00101 ADDI / 00111 SUBI: wr_acc=1, sel_a=10, sel_b=1, op=0/1, wr_pc=1; go to FETCH.
  - 00010 LD / 00100 ADD / 00110 SUB: rd_ram=1; go to MEMWAIT.
  - Any other opcode: NOP; wr_pc=1 only; go to FETCH.
- MEMWAIT, for the opcode held in ir:
  - LD: wr_acc=1, sel_a=00.
  - ADD/SUB: wr_acc=1, sel_a=10, sel_b=0, op=0/1.
  - All three also assert wr_pc=1; go to FETCH.
- HALT: halted=1, strobes 0, cycles frozen. start is ignored; only reset leaves HALT.
- Instruction timing: 2 cycles for immediate/STO/NOP, 3 for LD/ADD/SUB. wr_pc is a single-cycle pulse on the last cycle of each instruction.
- cycles: +1 on every clock spent in FETCH, EXEC or MEMWAIT. Saturates at 2^CNT_W-1, no wrap.
- start while in FETCH/EXEC/MEMWAIT is ignored.
- operand = ir[10:0] in every state; 0 after reset.

Decomposition:
- Shared package `bip_pkg`:
  - opcode localparams (OPC_HLT..OPC_SUBI)
  - sel_a encodings (SELA_MEM/IMM/ALU)
  - op encodings
  - state encoding (IDLE, FETCH, EXEC, MEMWAIT, HALT; 3 bits)
- One natural sub-module: `bip_decoder`, purely combinational (state, opcode) -> strobes and next state. The top holds the state register, ir and the counter.

Test Plan:
- Reset mid-MEMWAIT of an ADD: assert reset asynchronously, mid-cycle -> state IDLE, all outputs 0 and cycles=0 before the next edge; operand=0.
- start; instr_in=16'h1805 (LDI 5) then 16'h0000 (HLT):
  - EXEC cycle: wr_acc=1, sel_a=01, operand=5, wr_pc=1.
  - HLT reached: halted=1, cycles=4, wr_pc never asserted for HLT.
- ADD 3 (16'h2003) followed by HLT: rd_ram=1 in EXEC; next cycle wr_acc=1, sel_a=10, sel_b=0, op=0, wr_pc=1; exactly 3 cycles from FETCH to the next FETCH.
- SUBI 7 (16'h3807): EXEC gives op=1, sel_b=1, sel_a=10, wr_acc=1. STO 9 (16'h0809): EXEC gives wr_ram=1, operand=9, wr_acc=0.
- Illegal opcode 5'b11111 -> only wr_pc=1 in EXEC. start pulses during run and in HALT -> no effect; cycles unchanged in HALT.
- CNT_W=4, 10 LDI instructions then HLT -> cycles saturates at 15 and stays there.
